// File: rtl/speed_button_selector.sv
// speed_button_selector
//   Turns two raw push-buttons (up/down) into a clean, saturating 3-bit speed
//   code. Each button is synchronised, debounced and fed to a press FSM that
//   emits one step per press, then auto-repeats while the button is held.
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_btn_up    raw bouncy button, pressed = 1, requests speed+1
//   i_btn_down  raw bouncy button, pressed = 1, requests speed-1
//   o_speed     current speed code
//   o_changed   one-cycle pulse on every actual speed change
//   o_at_max    o_speed == 7
//   o_at_min    o_speed == 0

// Per-button lane: 2-FF synchroniser, debounce counter, press/repeat FSM.
module speed_button_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_step
);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = (HMAX > 2) ? $clog2(HMAX) : 1;

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  DLY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0]  RPT_LAST = HW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic           r_sync1;
    logic           r_sync2;
    logic           r_deb;
    logic [DBW-1:0] r_db_cnt;
    state_t         r_state;
    logic [HW-1:0]  r_hold_cnt;
    logic           w_step;

    // Synchroniser + debounce: the level flips only after the synchronised
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_deb    <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_deb) begin
                if (r_db_cnt == DB_LAST) begin
                    r_deb    <= ~r_deb;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Press FSM. r_hold_cnt counts cycles inside DELAY / REPEAT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
                    if (r_deb) r_state <= DELAY;
                end
                DELAY: begin
                    if (!r_deb) begin
                        r_state    <= IDLE;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == DLY_LAST) begin
                        r_state    <= REPEAT;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!r_deb) begin
                        r_state    <= IDLE;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == RPT_LAST) begin
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    // Step is decoded from the FSM state rather than registered so the speed
    // register sees it on the same edge the FSM acts; that keeps press-to-speed
    // latency at DEBOUNCE_CYCLES+2. Gating with r_deb means a release seen on
    // an expiry cycle never emits a step.
    always_comb begin
        w_step = 1'b0;
        case (r_state)
            IDLE:    w_step = r_deb;
            DELAY:   w_step = r_deb && (r_hold_cnt == DLY_LAST);
            REPEAT:  w_step = r_deb && (r_hold_cnt == RPT_LAST);
            default: w_step = 1'b0;
        endcase
    end

    assign o_step = w_step;
endmodule

module speed_button_selector #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_PERIOD   = 12500000,
    parameter logic [2:0] SPEED_INIT      = 3'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic [2:0] o_speed,
    output logic       o_changed,
    output logic       o_at_max,
    output logic       o_at_min
);
    localparam int NUM_LANES = 2;  // lane 0 = up, lane 1 = down

    logic [NUM_LANES-1:0] w_btn;
    logic [NUM_LANES-1:0] w_step;
    logic [2:0]           r_speed;
    logic                 r_changed;

    assign w_btn = {i_btn_down, i_btn_up};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            speed_button_lane #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_lane (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_btn   (w_btn[g]),
                .o_step  (w_step[g])
            );
        end
    endgenerate

    // Saturating update; coincident up+down steps cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_speed   <= SPEED_INIT;
            r_changed <= 1'b0;
        end else if (w_step == 2'b01 && r_speed != 3'd7) begin
            r_speed   <= r_speed + 3'd1;
            r_changed <= 1'b1;
        end else if (w_step == 2'b10 && r_speed != 3'd0) begin
            r_speed   <= r_speed - 3'd1;
            r_changed <= 1'b1;
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign o_speed   = r_speed;
    assign o_changed = r_changed;
    assign o_at_max  = (r_speed == 3'd7);
    assign o_at_min  = (r_speed == 3'd0);
endmodule

// File: tb/tb_speed_button_selector.sv
module tb_speed_button_selector;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] speed;
    logic       changed;
    logic       at_max;
    logic       at_min;

    int vectors = 0;
    int miscompares = 0;
    int chg_cnt = 0;

    always #5 clk = ~clk;

    speed_button_selector #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .SPEED_INIT      (3'd0)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn_up   (btn_up),
        .i_btn_down (btn_down),
        .o_speed    (speed),
        .o_changed  (changed),
        .o_at_max   (at_max),
        .o_at_min   (at_min)
    );

    // Reference model: raw input delayed two edges, a run-length debouncer,
    // and "time held" arithmetic deciding when a step is due.
    logic m_d1 [2];
    logic m_d2 [2];
    logic m_deb [2];
    int   m_run [2];
    int   m_held [2];
    int   m_speed;
    int   m_changed;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_deb[b] = 0; m_run[b] = 0; m_held[b] = 0;
        end
        m_speed = 0;
        m_changed = 0;
    endtask

    task automatic model_edge();
        logic raw [2];
        logic step [2];
        logic s;
        raw[0] = btn_up;
        raw[1] = btn_down;
        for (int b = 0; b < 2; b++) begin
            s = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
            step[b] = 0;
            if (m_deb[b]) begin
                step[b] = (m_held[b] == 0) || (m_held[b] == RD) ||
                          (m_held[b] > RD && (m_held[b] - RD) % RP == 0);
                m_held[b]++;
            end else begin
                m_held[b] = 0;
            end
            if (s != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_deb[b] = ~m_deb[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_changed = 0;
        if (step[0] && !step[1] && m_speed < 7) begin
            m_speed++; m_changed = 1;
        end else if (step[1] && !step[0] && m_speed > 0) begin
            m_speed--; m_changed = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("speed", int'(speed), m_speed);
        check("changed", int'(changed), m_changed);
        check("at_max", int'(at_max), int'(m_speed == 7));
        check("at_min", int'(at_min), int'(m_speed == 0));
    endtask

    // One clock: advance the model at the edge, sample the DUT 1ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        if (changed) chg_cnt++;
        cmp_model();
    endtask

    task automatic do_reset();
        btn_up = 0; btn_down = 0;
        rst_n = 0;
        model_reset();
        #1;
        cmp_model();
        repeat (2) tick();
        rst_n = 1;
        chg_cnt = 0;
    endtask

    task automatic press(input logic u, input logic d, input int hold);
        btn_up = u; btn_down = d;
        repeat (hold) tick();
        btn_up = 0; btn_down = 0;
        repeat (12) tick();
    endtask

    task automatic go_to(input int s);
        do_reset();
        for (int k = 0; k < s; k++) press(1'b1, 1'b0, 10);
        chg_cnt = 0;
    endtask

    typedef struct {
        logic       up;
        logic       down;
        int         hold;
        int         start;
        int         exp_speed;
        int         exp_changes;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 10, 0, 1, 1};
        tbl[1] = '{1'b1, 1'b0, 60, 0, 6, 6};
        tbl[2] = '{1'b1, 1'b0, 10, 7, 7, 0};
        tbl[3] = '{1'b0, 1'b1, 10, 0, 0, 0};
        tbl[4] = '{1'b1, 1'b1, 10, 3, 3, 0};
        tbl[5] = '{1'b0, 1'b1, 10, 3, 2, 1};
        tbl[6] = '{1'b0, 1'b1, 24, 5, 3, 2};
        tbl[7] = '{1'b1, 1'b0, 60, 4, 7, 3};

        // Reset state
        do_reset();
        check("rst_speed", int'(speed), 0);
        check("rst_changed", int'(changed), 0);
        check("rst_at_min", int'(at_min), 1);
        check("rst_at_max", int'(at_max), 0);

        // Exact press latency: raw high before edge 0 -> speed moves at edge 6
        btn_up = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 5) begin
                check("lat_e5_speed", int'(speed), 0);
                check("lat_e5_at_min", int'(at_min), 1);
            end
            if (i == 6) begin
                check("lat_e6_speed", int'(speed), 1);
                check("lat_e6_changed", int'(changed), 1);
                check("lat_e6_at_min", int'(at_min), 0);
            end
        end
        btn_up = 0;
        repeat (12) tick();
        check("lat_speed_final", int'(speed), 1);
        check("lat_change_count", chg_cnt, 1);

        // Table-driven scenarios
        for (int t = 0; t < 8; t++) begin
            go_to(tbl[t].start);
            press(tbl[t].up, tbl[t].down, tbl[t].hold);
            check($sformatf("tbl%0d_speed", t), int'(speed), tbl[t].exp_speed);
            check($sformatf("tbl%0d_changes", t), chg_cnt, tbl[t].exp_changes);
        end

        // Bounce shorter than the debounce window never steps
        do_reset();
        for (int i = 0; i < 30; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            tick();
        end
        btn_up = 0;
        repeat (12) tick();
        check("bounce_speed", int'(speed), 0);
        check("bounce_changes", chg_cnt, 0);

        // Reset mid-press (btn_up in DELAY at speed 4)
        go_to(4);
        btn_up = 1;
        repeat (10) tick();
        rst_n = 0;
        model_reset();
        #1;
        check("midrst_speed", int'(speed), 0);
        check("midrst_at_min", int'(at_min), 1);
        repeat (2) tick();
        rst_n = 1;
        chg_cnt = 0;
        repeat (12) tick();
        check("midrst_refresh_speed", int'(speed), 1);
        check("midrst_refresh_changes", chg_cnt, 1);
        btn_up = 0;
        repeat (12) tick();

        // Randomized segments against the model
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 45);
            for (int i = 0; i < len; i++) begin
                if (mode == 0) begin
                    btn_up   = 1'($urandom_range(0, 1));
                    btn_down = 1'($urandom_range(0, 1));
                end else begin
                    btn_up   = (mode == 1) || (mode == 3);
                    btn_down = (mode == 2) || (mode == 3);
                end
                tick();
            end
            btn_up = 0; btn_down = 0;
            repeat ($urandom_range(0, 15)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
